// File: rtl/ascii_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter for the ASCII text stream.
// Bytes arriving while the FIFO is full are dropped and latched in a sticky overflow flag.
module ascii_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          clr_ovf,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic            tx_reg, tx_next;
   logic [7:0]      shift_reg;
   logic            pop, shift_en, bit_last;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]   level_reg;
   logic            overflow_reg;
   logic            push, drop;

   // in_ready is held low during reset even though level_reg is already zero
   assign in_ready = rst_n && ena && (level_reg < LW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign drop     = ena && in_valid && !in_ready;
   assign bit_last = (clk_cnt_reg == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
         if (drop)
            overflow_reg <= 1'b1;
         else if (clr_ovf)
            overflow_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= in_data;
   end

   // Registered read of the FIFO head straight into the shift register
   always_ff @(posedge clk) begin
      if (pop)
         shift_reg <= mem[rd_ptr_reg];
      else if (shift_en)
         shift_reg <= {1'b0, shift_reg[7:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         clk_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         clk_cnt_reg <= clk_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         tx_reg      <= tx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clk_cnt_next = clk_cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      tx_next      = tx_reg;
      pop          = 1'b0;
      shift_en     = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next      = 1'b1;
            clk_cnt_next = '0;
            if (level_reg != '0) begin
               pop        = 1'b1;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (bit_last) begin
               clk_cnt_next = '0;
               bit_cnt_next = '0;
               state_next   = DATA;
               tx_next      = shift_reg[0];
            end else begin
               clk_cnt_next = clk_cnt_reg + CW'(1);
            end
         end
         DATA: begin
            if (bit_last) begin
               clk_cnt_next = '0;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  shift_en     = 1'b1;
                  tx_next      = shift_reg[1];
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + CW'(1);
            end
         end
         STOP: begin
            tx_next = 1'b1;
            if (bit_last) begin
               clk_cnt_next = '0;
               // Chain straight into the next frame when data is waiting
               if (level_reg != '0) begin
                  pop        = 1'b1;
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign tx         = tx_reg;
   assign busy       = (state_reg != IDLE);
   assign fifo_level = level_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx: a serial monitor decodes tx and checks bytes against a scoreboard queue.
module tb_ascii_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       in_ready, tx, busy, overflow;
   logic [2:0] fifo_level;

   ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .clr_ovf    (clr_ovf),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         rx_count = 0;
   bit         mon_en = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n = 0;
      while ((busy !== 1'b0 || fifo_level !== 3'd0) && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(n < max_cyc), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Serial receiver: samples each bit mid-way from the negative clock edge
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
            start_q.push_back(cyc);
            @(negedge clk);
            check("rx_start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("rx_stop_bit", 32'(tx), 32'd1);
            rx_count++;
            check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
               check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 50000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s2_bytes [6];
      int         s2_lvl [6];
      int         n, rx_base;
      s2_bytes = '{8'h54, 8'h61, 8'h6A, 8'h75, 8'h6D, 8'h75};
      s2_lvl   = '{1, 1, 2, 3, 4, 4};

      // Reset state, with ena high so in_ready gating by reset is visible
      rst_n = 1'b0;
      ena   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // 1: single byte
      in_data = 8'h54; in_valid = 1'b1; exp_q.push_back(8'h54);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("s1_level_after_push", 32'(fifo_level), 32'd1);
      check("s1_tx_before_pop", 32'(tx), 32'd1);
      @(posedge clk); #1;
      check("s1_tx_fall", 32'(tx), 32'd0);
      check("s1_busy_rise", 32'(busy), 32'd1);
      check("s1_level_after_pop", 32'(fifo_level), 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      check("s1_busy_cycles", 32'(n), 32'd40);
      check("s1_tx_idle", 32'(tx), 32'd1);
      check("s1_level_end", 32'(fifo_level), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("s1_rx_count", 32'(rx_count), 32'd1);
      check("s1_queue_drained", 32'(exp_q.size()), 32'd0);

      // 2: six-byte burst, sixth dropped
      start_q.delete();
      rx_base = rx_count;
      for (int i = 0; i < 6; i++) begin
         in_data  = s2_bytes[i];
         in_valid = 1'b1;
         if (i < 5) exp_q.push_back(s2_bytes[i]);
         @(posedge clk); #1;
         check($sformatf("s2_level_%0d", i), 32'(fifo_level), 32'(s2_lvl[i]));
         check($sformatf("s2_overflow_%0d", i), 32'(overflow), 32'(i == 5));
      end
      in_valid = 1'b0;
      check("s2_in_ready_full", 32'(in_ready), 32'd0);
      wait_idle("s2_drain_timeout", 300);
      check("s2_rx_count", 32'(rx_count - rx_base), 32'd5);
      check("s2_queue_drained", 32'(exp_q.size()), 32'd0);
      check("s2_frame_starts", 32'(start_q.size()), 32'd5);
      for (int i = 1; i < 5; i++)
         if (i < start_q.size())
            check($sformatf("s2_gap_%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd40);
      check("s2_overflow_sticky", 32'(overflow), 32'd1);

      // 3: clear overflow
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      check("s3_overflow_cleared", 32'(overflow), 32'd0);

      // 4: enable gating with a frame in flight and one byte queued
      rx_base = rx_count;
      in_data = 8'h4B; in_valid = 1'b1; exp_q.push_back(8'h4B);
      @(posedge clk); #1;
      in_data = 8'h4C; exp_q.push_back(8'h4C);
      @(posedge clk); #1;
      check("s4_level_queued", 32'(fifo_level), 32'd1);
      ena = 1'b0; in_data = 8'h58;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("s4_in_ready_%0d", i), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         check($sformatf("s4_overflow_%0d", i), 32'(overflow), 32'd0);
      end
      check("s4_busy_in_flight", 32'(busy), 32'd1);
      in_valid = 1'b0; ena = 1'b1;
      wait_idle("s4_drain_timeout", 200);
      check("s4_rx_count", 32'(rx_count - rx_base), 32'd2);
      check("s4_queue_drained", 32'(exp_q.size()), 32'd0);

      // 5: reset during DATA bit 3 of 0x41 (bit value 0)
      mon_en = 1'b0;
      in_data = 8'h41; in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = 8'h42;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      check("s5_tx_bit3", 32'(tx), 32'd0);
      check("s5_level_before", 32'(fifo_level), 32'd1);
      rst_n = 1'b0;
      #1;
      check("s5_rst_tx", 32'(tx), 32'd1);
      check("s5_rst_busy", 32'(busy), 32'd0);
      check("s5_rst_level", 32'(fifo_level), 32'd0);
      check("s5_rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1) n++;
         if (busy !== 1'b0) n++;
      end
      check("s5_no_residual_frame", 32'(n), 32'd0);
      mon_en = 1'b1;

      // 6: 20 bytes spaced 37 cycles apart, several pointer wraps
      rx_base = rx_count;
      for (int k = 0; k < 20; k++) begin
         in_data  = 8'h20 + 8'(k);
         in_valid = 1'b1;
         exp_q.push_back(8'h20 + 8'(k));
         @(posedge clk); #1;
         in_valid = 1'b0;
         repeat (36) @(posedge clk);
         #1;
      end
      wait_idle("s6_drain_timeout", 300);
      check("s6_rx_count", 32'(rx_count - rx_base), 32'd20);
      check("s6_queue_drained", 32'(exp_q.size()), 32'd0);
      check("s6_overflow", 32'(overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
